// File: rtl/stream_upsizer.sv
// -----------------------------------------------------------------------------
// stream_upsizer
//
// Narrow-to-wide valid/ready stream packer. Gathers RATIO consecutive
// DATA_WIDTH beats into one DATA_WIDTH*RATIO word. The first accepted beat
// lands in the least-significant lane. The output word is registered.
// Throughput is one narrow beat per cycle, with no bubbles, while ready_m is high.
//
// Parameters
//   DATA_WIDTH  width of one input beat
//   RATIO       input beats per output word (>= 2, any integer)
//
// Ports
//   clk      clock; all state updates on posedge
//   rst      synchronous, active-high reset
//   ready_s  upstream may transfer when valid_s && ready_s
//   valid_s  input beat valid
//   data_s   input beat
//   ready_m  downstream accepts the output word
//   valid_m  output word valid (registered)
//   data_m   packed output word (registered)
//   last_s   [STREAM_UPSIZER_LAST_EN] final beat of a packet
//   last_m   [STREAM_UPSIZER_LAST_EN] word ends a packet
//   keep_m   [STREAM_UPSIZER_LAST_EN] lane-valid mask, bit i = lane i
//
// Build option
//   STREAM_UPSIZER_LAST_EN  When defined, the packet ports are added, and a beat
//                           with last_s flushes a partial word.
//
// ready_s depends combinationally on ready_m (and on last_s when packet
// support is built in). Place a registered stage in front of this block if
// that path is timing-critical.
// -----------------------------------------------------------------------------
module stream_upsizer #(
  parameter int DATA_WIDTH = 8,
  parameter int RATIO      = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        ready_s,
  input  logic                        valid_s,
  input  logic [DATA_WIDTH-1:0]       data_s,
  input  logic                        ready_m,
  output logic                        valid_m,
  output logic [DATA_WIDTH*RATIO-1:0] data_m
`ifdef STREAM_UPSIZER_LAST_EN
  ,
  input  logic                        last_s,
  output logic                        last_m,
  output logic [RATIO-1:0]            keep_m
`endif
);

  localparam int IDX_W = ($clog2(RATIO) > 1) ? $clog2(RATIO) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  logic [IDX_W-1:0]                  idx_q, idx_d;
  logic [RATIO-2:0][DATA_WIDTH-1:0]  acc_q, acc_d;
  logic                              valid_m_q, valid_m_d;
  logic [DATA_WIDTH*RATIO-1:0]       data_m_q, data_m_d;

  logic flush;
  logic at_last_lane;
  logic accept;
  logic emit;

`ifdef STREAM_UPSIZER_LAST_EN
  logic             last_m_q, last_m_d;
  logic [RATIO-1:0] keep_m_q, keep_m_d;
  assign flush = last_s;
`else
  assign flush = 1'b0;
`endif

  assign at_last_lane = (idx_q == LAST_IDX);

  // Non-final lanes go into the accumulator. They can be taken even while the
  // output register is stalled. Only a beat that closes a word needs the
  // output register to be free.
  assign ready_s = !valid_m_q || ready_m || (!at_last_lane && !flush);
  assign accept  = valid_s && ready_s;
  assign emit    = accept && (at_last_lane || flush);

  always_comb begin
    // NOTE: every variable gets its hold value first. This way no path through
    // the branches below leaves one unassigned, and no latch is inferred.
    idx_d     = idx_q;
    acc_d     = acc_q;
    valid_m_d = valid_m_q;
    data_m_d  = data_m_q;
`ifdef STREAM_UPSIZER_LAST_EN
    last_m_d  = last_m_q;
    keep_m_d  = keep_m_q;
`endif

    if (emit) begin
      // The new word is {data_s at lane idx, gathered lanes below}. Lanes above
      // idx are zero (only reachable on a flush). If ready_m is also high in
      // this cycle, this overwrites the word being consumed, so no bubble occurs.
      data_m_d = '0;
      for (int i = 0; i < RATIO - 1; i++) begin
        if (IDX_W'(i) < idx_q) data_m_d[i*DATA_WIDTH +: DATA_WIDTH] = acc_q[i];
      end
      for (int i = 0; i < RATIO; i++) begin
        if (IDX_W'(i) == idx_q) data_m_d[i*DATA_WIDTH +: DATA_WIDTH] = data_s;
      end
`ifdef STREAM_UPSIZER_LAST_EN
      for (int i = 0; i < RATIO; i++) begin
        keep_m_d[i] = (IDX_W'(i) <= idx_q);
      end
      last_m_d = last_s;
`endif
      valid_m_d = 1'b1;
      idx_d     = '0;
    end else begin
      if (accept) begin
        for (int i = 0; i < RATIO - 1; i++) begin
          if (IDX_W'(i) == idx_q) acc_d[i] = data_s;
        end
        idx_d = idx_q + 1'b1;
      end
      if (ready_m) valid_m_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q     <= '0;
      // NOTE: the accumulator and the output data are cleared here even though
      // valid_m alone gates them. A reset must leave no trace of a partially
      // gathered packet, and a stable all-zero output is easier to debug.
      acc_q     <= '0;
      valid_m_q <= 1'b0;
      data_m_q  <= '0;
`ifdef STREAM_UPSIZER_LAST_EN
      last_m_q  <= 1'b0;
      keep_m_q  <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments. All flops sample their _d values
      // together at the edge, regardless of the statement order.
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      valid_m_q <= valid_m_d;
      data_m_q  <= data_m_d;
`ifdef STREAM_UPSIZER_LAST_EN
      last_m_q  <= last_m_d;
      keep_m_q  <= keep_m_d;
`endif
    end
  end

  assign valid_m = valid_m_q;
  assign data_m  = data_m_q;
`ifdef STREAM_UPSIZER_LAST_EN
  assign last_m  = last_m_q;
  assign keep_m  = keep_m_q;
`endif

endmodule

// File: tb/tb_stream_upsizer.sv
// -----------------------------------------------------------------------------
// tb_stream_upsizer
//
// Self-checking bench for stream_upsizer with DATA_WIDTH=8 and RATIO=4.
// A negedge monitor keeps a queue-based reference model. Accepted beats
// collect into a partial word. Completed words wait in an expected-word queue
// until the consumer takes them. Directed sequences cover streaming,
// backpressure, simultaneous load/consume, reset mid-packet and (when built
// with STREAM_UPSIZER_LAST_EN) packet flushes. A randomized run of 10k beats
// follows.
// -----------------------------------------------------------------------------
module tb_stream_upsizer;

  localparam int DW    = 8;
  localparam int RATIO = 4;
  localparam int WW    = DW * RATIO;
`ifdef STREAM_UPSIZER_LAST_EN
  localparam bit LAST_EN = 1'b1;
`else
  localparam bit LAST_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          ready_s;
  logic          valid_s;
  logic [DW-1:0] data_s;
  logic          ready_m;
  logic          valid_m;
  logic [WW-1:0] data_m;
  logic          last_s;
`ifdef STREAM_UPSIZER_LAST_EN
  logic             last_m;
  logic [RATIO-1:0] keep_m;
`endif

  stream_upsizer #(.DATA_WIDTH(DW), .RATIO(RATIO)) dut (
    .clk     (clk),
    .rst     (rst),
    .ready_s (ready_s),
    .valid_s (valid_s),
    .data_s  (data_s),
    .ready_m (ready_m),
    .valid_m (valid_m),
    .data_m  (data_m)
`ifdef STREAM_UPSIZER_LAST_EN
    ,
    .last_s  (last_s),
    .last_m  (last_m),
    .keep_m  (keep_m)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model (negedge monitor) ----------------
  typedef struct {
    logic [WW-1:0]    data;
    logic [RATIO-1:0] keep;
    logic             last;
  } word_t;

  word_t         exp_q[$];
  logic [DW-1:0] part_q[$];
  word_t         w_new;
  word_t         w_old;
  logic          prev_stall = 1'b0;
  logic [WW-1:0] prev_data;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      part_q.delete();
      prev_stall = 1'b0;
    end else begin
      check("valid_m", valid_m, exp_q.size() != 0);
      check("ready_s", ready_s, (exp_q.size() == 0) || ready_m ||
            ((part_q.size() != RATIO - 1) && !(LAST_EN && last_s)));
      if (prev_stall) check("hold_data", data_m, prev_data);

      if (valid_m && ready_m && exp_q.size() != 0) begin
        w_old = exp_q.pop_front();
        check("sb_data", data_m, w_old.data);
`ifdef STREAM_UPSIZER_LAST_EN
        check("sb_keep", keep_m, w_old.keep);
        check("sb_last", last_m, w_old.last);
`endif
      end

      if (valid_s && ready_s) begin
        part_q.push_back(data_s);
        if (part_q.size() == RATIO || (LAST_EN && last_s)) begin
          w_new.data = '0;
          w_new.keep = '0;
          w_new.last = LAST_EN && last_s;
          foreach (part_q[i]) begin
            w_new.data[i*DW +: DW] = part_q[i];
            w_new.keep[i]          = 1'b1;
          end
          exp_q.push_back(w_new);
          part_q.delete();
        end
      end

      prev_stall = valid_m && !ready_m;
      prev_data  = data_m;
    end
  end

  // ---------------- stimulus ----------------
  // Called just after a posedge. Applies one cycle of inputs, samples ready_s
  // once it has settled, and returns just after the next posedge.
  task automatic drive(input logic v, input logic [DW-1:0] d, input logic l,
                       input logic rm, output logic rdy);
    valid_s = v;
    data_s  = d;
    last_s  = l;
    ready_m = rm;
    #1;
    rdy = ready_s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic rdy;
    int   acc_n;
    int   cyc;

    rst = 1'b1; valid_s = 1'b0; data_s = '0; last_s = 1'b0; ready_m = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_valid", valid_m, 0);
    check("reset_data",  data_m, 0);
    check("reset_ready", ready_s, 1);

    // Streaming: 0x11..0x44, then 8 beats that give two words with no bubble.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, DW'((i + 1) * 'h11), 1'b0, 1'b1, rdy);
      check("stream_rdy", rdy, 1);
    end
    check("stream_valid", valid_m, 1);
    check("stream_word",  data_m, 32'h4433_2211);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, DW'('h50 + i), 1'b0, 1'b1, rdy);
      check("stream2_rdy",   rdy, 1);
      check("stream2_valid", valid_m, (i % 4) == 3);
    end
    check("stream2_word", data_m, 32'h5756_5554);
    drive(1'b0, '0, 1'b0, 1'b1, rdy);

    // Backpressure, then a final beat that meets the consuming cycle.
    for (int i = 0; i < 4; i++) drive(1'b1, DW'('hB0 + i), 1'b0, 1'b0, rdy);
    check("bp_word", data_m, 32'hB3B2_B1B0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, DW'('hC0 + i), 1'b0, 1'b0, rdy);
      check("bp_accept", rdy, 1);
    end
    repeat (2) begin
      drive(1'b1, 8'hC3, 1'b0, 1'b0, rdy);
      check("bp_stall_rdy", rdy, 0);
      check("bp_hold",      data_m, 32'hB3B2_B1B0);
    end
    drive(1'b1, 8'hC3, 1'b0, 1'b1, rdy);
    check("simul_rdy",   rdy, 1);
    check("simul_valid", valid_m, 1);
    check("simul_word",  data_m, 32'hC3C2_C1C0);
    drive(1'b0, '0, 1'b0, 1'b1, rdy);
    check("drain_valid", valid_m, 0);

    // Reset mid-packet with a stalled word pending.
    for (int i = 0; i < 4; i++) drive(1'b1, DW'('hE0 + i), 1'b0, 1'b0, rdy);
    for (int i = 0; i < 2; i++) drive(1'b1, DW'('hD0 + i), 1'b0, 1'b0, rdy);
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0, rdy);
    rst = 1'b0;
    check("rst_valid", valid_m, 0);
    check("rst_data",  data_m, 0);
    for (int i = 0; i < 4; i++) drive(1'b1, DW'('hA1 + i), 1'b0, 1'b1, rdy);
    check("rst_word", data_m, 32'hA4A3_A2A1);
    drive(1'b0, '0, 1'b0, 1'b1, rdy);

`ifdef STREAM_UPSIZER_LAST_EN
    drive(1'b1, 8'h01, 1'b0, 1'b1, rdy);
    drive(1'b1, 8'h02, 1'b1, 1'b1, rdy);
    check("last2_data", data_m, 32'h0000_0201);
    check("last2_keep", keep_m, 4'b0011);
    check("last2_last", last_m, 1);
    drive(1'b1, 8'h05, 1'b1, 1'b1, rdy);
    check("last1_data", data_m, 32'h0000_0005);
    check("last1_keep", keep_m, 4'b0001);
    check("last1_last", last_m, 1);
    for (int i = 0; i < 4; i++) drive(1'b1, DW'('h61 + i), i == 3, 1'b1, rdy);
    check("last4_keep", keep_m, 4'b1111);
    check("last4_last", last_m, 1);
    drive(1'b0, '0, 1'b0, 1'b1, rdy);
`endif

    // Random traffic against the scoreboard.
    acc_n = 0;
    cyc   = 0;
    while (acc_n < 10000 && cyc < 60000) begin
      logic v;
      v = ($urandom_range(0, 99) < 70);
      drive(v, DW'($urandom), LAST_EN && ($urandom_range(0, 9) == 0),
            $urandom_range(0, 99) < 60, rdy);
      if (v && rdy) acc_n++;
      cyc++;
    end
    check("rand_beats", acc_n, 10000);
    repeat (3) drive(1'b0, '0, 1'b0, 1'b1, rdy);
    check("drain_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
